gestor_niveles: RTL and testbench

- Upstream level generator for the pet state machine. Produces the four 2-bit need levels it consumes: comida, salud, descanso, animo.
- Each level decays over time and recovers while its stimulus is held: boton_comida, boton_medicina, sensor_luz, sensor_ultrasonido.
- Also flags critical levels and a sticky death condition, for the display and the game-over logic.

---
 rtl/gestor_niveles_pkg.sv | 22 ++
 rtl/canal_nivel.sv | 66 ++++++
 rtl/gestor_niveles.sv | 109 ++++++++++
 tb/tb_gestor_niveles.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/gestor_niveles_pkg.sv
// Shared types, constants and width helper for the need-level generator.
package gestor_niveles_pkg;

  localparam int unsigned NIVEL_W = 2;

  typedef logic [NIVEL_W-1:0] nivel_t;

  localparam nivel_t NIVEL_MAX = 2'd3;
  localparam nivel_t NIVEL_MIN = 2'd0;

  localparam int unsigned IDX_COMIDA   = 0;
  localparam int unsigned IDX_SALUD    = 1;
  localparam int unsigned IDX_DESCANSO = 2;
  localparam int unsigned IDX_ANIMO    = 3;
  localparam int unsigned N_CANALES    = 4;

  // Counter width for a 0..p-1 counter; a period of 1 still needs one bit.
  function automatic int unsigned ancho_cnt(input int unsigned p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/canal_nivel.sv
// One need channel: level decays without stimulus and recovers while stimulus is held.
module canal_nivel
  import gestor_niveles_pkg::*;
#(
  parameter int unsigned DECAY         = 30,
  parameter int unsigned RECOVER_TICKS = 3
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   tick,
  input  logic   estimulo,
  output nivel_t nivel,
  output logic   en_cero
);

  localparam int unsigned DW = ancho_cnt(DECAY);
  localparam int unsigned RW = ancho_cnt(RECOVER_TICKS);
  localparam logic [DW-1:0] DECAY_FIN   = DW'(DECAY - 1);
  localparam logic [RW-1:0] RECOVER_FIN = RW'(RECOVER_TICKS - 1);

  logic [DW-1:0] dec_q, dec_d;
  logic [RW-1:0] rec_q, rec_d;
  nivel_t        nivel_d;

  // Stimulus takes priority over decay; each side clears the other's progress.
  always_comb begin
    dec_d   = dec_q;
    rec_d   = rec_q;
    nivel_d = nivel;
    if (tick) begin
      if (estimulo) begin
        dec_d = '0;
        if (rec_q == RECOVER_FIN) begin
          rec_d = '0;
          if (nivel != NIVEL_MAX) nivel_d = nivel + NIVEL_W'(1);
        end else begin
          rec_d = rec_q + RW'(1);
        end
      end else begin
        rec_d = '0;
        if (dec_q == DECAY_FIN) begin
          dec_d = '0;
          if (nivel != NIVEL_MIN) nivel_d = nivel - NIVEL_W'(1);
        end else begin
          dec_d = dec_q + DW'(1);
        end
      end
    end
  end

  // en_cero is registered from the next level so it lines up with nivel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_q   <= '0;
      rec_q   <= '0;
      nivel   <= NIVEL_MAX;
      en_cero <= 1'b0;
    end else begin
      dec_q   <= dec_d;
      rec_q   <= rec_d;
      nivel   <= nivel_d;
      en_cero <= (nivel_d == NIVEL_MIN);
    end
  end

endmodule

// File: rtl/gestor_niveles.sv
// Need-level generator: base-tick prescaler, four level channels, alert packing and sticky death flag.
module gestor_niveles
  import gestor_niveles_pkg::*;
#(
  parameter int unsigned CLK_PER_TICK   = 50_000_000,
  parameter int unsigned DECAY_COMIDA   = 30,
  parameter int unsigned DECAY_SALUD    = 60,
  parameter int unsigned DECAY_DESCANSO = 45,
  parameter int unsigned DECAY_ANIMO    = 20,
  parameter int unsigned RECOVER_TICKS  = 3,
  parameter int unsigned DEATH_TICKS    = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               test_rapido,
  input  logic               boton_comida,
  input  logic               boton_medicina,
  input  logic               sensor_luz,
  input  logic               sensor_ultrasonido,
  output logic [NIVEL_W-1:0] nivel_comida,
  output logic [NIVEL_W-1:0] nivel_salud,
  output logic [NIVEL_W-1:0] nivel_descanso,
  output logic [NIVEL_W-1:0] nivel_animo,
  output logic [N_CANALES-1:0] alerta,
  output logic               muerte,
  output logic               tick
);

  localparam int unsigned PW = ancho_cnt(CLK_PER_TICK);
  localparam int unsigned MW = ancho_cnt(DEATH_TICKS);
  localparam logic [PW-1:0] PRE_FIN   = PW'(CLK_PER_TICK - 1);
  localparam logic [MW-1:0] MUERTE_FIN = MW'(DEATH_TICKS - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic          muerte_d;
  logic [N_CANALES-1:0] cero;

  // Fast mode pins the prescaler at 0, so leaving it restarts a full period (no double tick).
  always_comb begin
    pre_d  = pre_q;
    tick_d = 1'b0;
    if (test_rapido) begin
      pre_d  = '0;
      tick_d = 1'b1;
    end else if (pre_q == PRE_FIN) begin
      pre_d  = '0;
      tick_d = 1'b1;
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  // Death counter: consecutive ticks with any level at zero.
  always_comb begin
    mcnt_d   = mcnt_q;
    muerte_d = muerte;
    if (tick) begin
      if (alerta != '0) begin
        if (mcnt_q == MUERTE_FIN) begin
          mcnt_d   = '0;
          muerte_d = 1'b1;
        end else begin
          mcnt_d = mcnt_q + MW'(1);
        end
      end else begin
        mcnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q  <= '0;
      tick   <= 1'b0;
      mcnt_q <= '0;
      muerte <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick   <= tick_d;
      mcnt_q <= mcnt_d;
      muerte <= muerte_d;
    end
  end

  canal_nivel #(.DECAY(DECAY_COMIDA), .RECOVER_TICKS(RECOVER_TICKS)) u_comida (
    .clk(clk), .reset(reset), .tick(tick), .estimulo(boton_comida),
    .nivel(nivel_comida), .en_cero(cero[IDX_COMIDA])
  );

  canal_nivel #(.DECAY(DECAY_SALUD), .RECOVER_TICKS(RECOVER_TICKS)) u_salud (
    .clk(clk), .reset(reset), .tick(tick), .estimulo(boton_medicina),
    .nivel(nivel_salud), .en_cero(cero[IDX_SALUD])
  );

  canal_nivel #(.DECAY(DECAY_DESCANSO), .RECOVER_TICKS(RECOVER_TICKS)) u_descanso (
    .clk(clk), .reset(reset), .tick(tick), .estimulo(sensor_luz),
    .nivel(nivel_descanso), .en_cero(cero[IDX_DESCANSO])
  );

  canal_nivel #(.DECAY(DECAY_ANIMO), .RECOVER_TICKS(RECOVER_TICKS)) u_animo (
    .clk(clk), .reset(reset), .tick(tick), .estimulo(sensor_ultrasonido),
    .nivel(nivel_animo), .en_cero(cero[IDX_ANIMO])
  );

  assign alerta = cero;

endmodule

// File: tb/tb_gestor_niveles.sv
// Directed, table-driven bench for gestor_niveles with small periods.
module tb_gestor_niveles;

  logic       clk = 1'b0;
  logic       reset;
  logic       test_rapido;
  logic       boton_comida, boton_medicina, sensor_luz, sensor_ultrasonido;
  logic [1:0] nivel_comida, nivel_salud, nivel_descanso, nivel_animo;
  logic [3:0] alerta;
  logic       muerte;
  logic       tick;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gestor_niveles #(
    .CLK_PER_TICK(4), .DECAY_COMIDA(3), .DECAY_SALUD(3), .DECAY_DESCANSO(3),
    .DECAY_ANIMO(3), .RECOVER_TICKS(2), .DEATH_TICKS(2)
  ) dut (
    .clk(clk), .reset(reset), .test_rapido(test_rapido),
    .boton_comida(boton_comida), .boton_medicina(boton_medicina),
    .sensor_luz(sensor_luz), .sensor_ultrasonido(sensor_ultrasonido),
    .nivel_comida(nivel_comida), .nivel_salud(nivel_salud),
    .nivel_descanso(nivel_descanso), .nivel_animo(nivel_animo),
    .alerta(alerta), .muerte(muerte), .tick(tick)
  );

  typedef struct {
    logic       rst;
    logic       rap;
    logic [3:0] est;   // {animo, descanso, salud, comida}
    logic [1:0] c, s, d, a;
    logic [3:0] al;
    logic       m;
    logic       t;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic rap, input logic [3:0] est,
                     input logic [1:0] c, input logic [1:0] s, input logic [1:0] d,
                     input logic [1:0] a, input logic [3:0] al, input logic m, input logic t);
    vec_t v;
    v.rst = r; v.rap = rap; v.est = est;
    v.c = c; v.s = s; v.d = d; v.a = a;
    v.al = al; v.m = m; v.t = t;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL v%0d %s: got %0h expected %0h", idx, nm, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [1:0] c, input logic [1:0] s,
                         input logic [1:0] d, input logic [1:0] a, input logic [3:0] al,
                         input logic m, input logic t);
    vectors++;
    chk("nivel_comida",   idx, 4'(nivel_comida),   4'(c));
    chk("nivel_salud",    idx, 4'(nivel_salud),    4'(s));
    chk("nivel_descanso", idx, 4'(nivel_descanso), 4'(d));
    chk("nivel_animo",    idx, 4'(nivel_animo),    4'(a));
    chk("alerta",         idx, alerta,             al);
    chk("muerte",         idx, 4'(muerte),         4'(m));
    chk("tick",           idx, 4'(tick),           4'(t));
  endtask

  initial begin
    reset = 1'b0; test_rapido = 1'b0;
    boton_comida = 1'b0; boton_medicina = 1'b0; sensor_luz = 1'b0; sensor_ultrasonido = 1'b0;

    // Normal mode: tick every 4th cycle, levels hold over 8 cycles
    add(0,0,4'h0, 3,3,3,3, 4'h0,0,0);
    add(0,0,4'h0, 3,3,3,3, 4'h0,0,0);
    add(0,0,4'h0, 3,3,3,3, 4'h0,0,0);
    add(0,0,4'h0, 3,3,3,3, 4'h0,0,1);
    add(0,0,4'h0, 3,3,3,3, 4'h0,0,0);
    add(0,0,4'h0, 3,3,3,3, 4'h0,0,0);
    add(0,0,4'h0, 3,3,3,3, 4'h0,0,0);
    add(0,0,4'h0, 3,3,3,3, 4'h0,0,1);
    add(1,0,4'h0, 3,3,3,3, 4'h0,0,0);
    // Fast mode decay to 0, then death two ticks later
    add(0,1,4'h0, 3,3,3,3, 4'h0,0,1);
    add(0,1,4'h0, 3,3,3,3, 4'h0,0,1);
    add(0,1,4'h0, 3,3,3,3, 4'h0,0,1);
    add(0,1,4'h0, 2,2,2,2, 4'h0,0,1);
    add(0,1,4'h0, 2,2,2,2, 4'h0,0,1);
    add(0,1,4'h0, 2,2,2,2, 4'h0,0,1);
    add(0,1,4'h0, 1,1,1,1, 4'h0,0,1);
    add(0,1,4'h0, 1,1,1,1, 4'h0,0,1);
    add(0,1,4'h0, 1,1,1,1, 4'h0,0,1);
    add(0,1,4'h0, 0,0,0,0, 4'hF,0,1);
    add(0,1,4'h0, 0,0,0,0, 4'hF,0,1);
    add(0,1,4'h0, 0,0,0,0, 4'hF,1,1);
    add(0,1,4'h0, 0,0,0,0, 4'hF,1,1);
    add(0,1,4'h0, 0,0,0,0, 4'hF,1,1);
    // Feed recovery with a one-tick drop mid-recovery, then saturation at 3
    add(0,1,4'h1, 0,0,0,0, 4'hF,1,1);
    add(0,1,4'h1, 1,0,0,0, 4'hE,1,1);
    add(0,1,4'h1, 1,0,0,0, 4'hE,1,1);
    add(0,1,4'h0, 1,0,0,0, 4'hE,1,1);
    add(0,1,4'h1, 1,0,0,0, 4'hE,1,1);
    add(0,1,4'h1, 2,0,0,0, 4'hE,1,1);
    add(0,1,4'h1, 2,0,0,0, 4'hE,1,1);
    add(0,1,4'h1, 3,0,0,0, 4'hE,1,1);
    add(0,1,4'h1, 3,0,0,0, 4'hE,1,1);
    add(0,1,4'h1, 3,0,0,0, 4'hE,1,1);
    // Stimulus on the decay-expiry tick at level 2 blocks the drop and restarts decay
    add(0,1,4'h0, 3,0,0,0, 4'hE,1,1);
    add(0,1,4'h0, 3,0,0,0, 4'hE,1,1);
    add(0,1,4'h0, 2,0,0,0, 4'hE,1,1);
    add(0,1,4'h0, 2,0,0,0, 4'hE,1,1);
    add(0,1,4'h0, 2,0,0,0, 4'hE,1,1);
    add(0,1,4'h1, 2,0,0,0, 4'hE,1,1);
    add(0,1,4'h0, 2,0,0,0, 4'hE,1,1);
    add(0,1,4'h0, 2,0,0,0, 4'hE,1,1);
    add(0,1,4'h0, 1,0,0,0, 4'hE,1,1);
    // Back to normal mode: prescaler restarts from 0, no extra tick
    add(0,0,4'h0, 1,0,0,0, 4'hE,1,0);
    add(0,0,4'h0, 1,0,0,0, 4'hE,1,0);
    add(0,0,4'h0, 1,0,0,0, 4'hE,1,0);
    add(0,0,4'h0, 1,0,0,0, 4'hE,1,1);
    add(0,0,4'h0, 1,0,0,0, 4'hE,1,0);
    add(0,0,4'h0, 1,0,0,0, 4'hE,1,0);
    add(0,0,4'h0, 1,0,0,0, 4'hE,1,0);
    add(0,0,4'h0, 1,0,0,0, 4'hE,1,1);
    add(0,0,4'h0, 0,0,0,0, 4'hF,1,0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all(0, 2'd3, 2'd3, 2'd3, 2'd3, 4'h0, 1'b0, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      reset              = ~vq[i].rst;
      test_rapido        = vq[i].rap;
      boton_comida       = vq[i].est[0];
      boton_medicina     = vq[i].est[1];
      sensor_luz         = vq[i].est[2];
      sensor_ultrasonido = vq[i].est[3];
      @(posedge clk);
      #1;
      chk_all(i + 1, vq[i].c, vq[i].s, vq[i].d, vq[i].a, vq[i].al, vq[i].m, vq[i].t);
    end

    // Asynchronous reset with muerte high: takes effect before any clock edge
    #2;
    reset = 1'b0;
    #1;
    chk_all(1000, 2'd3, 2'd3, 2'd3, 2'd3, 4'h0, 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_all(1001, 2'd3, 2'd3, 2'd3, 2'd3, 4'h0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
